// File: rtl/smg_number_convert.sv
// Binary-to-BCD converter for a 6-digit seven-segment display.
// Iterative double-dabble, one bit per clock; saturates at MAX_VALUE.
module smg_number_convert #(
   parameter logic [19:0] MAX_VALUE = 20'd999999
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        Start_Sig,
   input  logic [19:0] Bin_Data,
   output logic        Busy_Sig,
   output logic        Done_Sig,
   output logic        Over_Sig,
   output logic [23:0] Number_Sig
);

   localparam logic [4:0] LastStep = 5'd19;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e      r_state;
   state_e      w_state_next;
   logic [19:0] r_operand;
   logic [23:0] r_bcd;
   logic [4:0]  r_cnt;
   logic        r_ovf;
   logic        r_done;
   logic        r_over;
   logic [23:0] r_number;

   logic [23:0] w_bcd_adj;
   logic [43:0] w_shifted;
   logic [23:0] w_bcd_next;
   logic [19:0] w_op_next;
   logic        w_last;
   logic        w_sat;

   assign w_sat  = (Bin_Data > MAX_VALUE);
   assign w_last = (r_state == StShift) && (r_cnt == LastStep);

   // Pre-shift correction keeps every nibble a legal decimal digit after the shift.
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < 6; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) begin
            w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   assign w_shifted  = {w_bcd_adj, r_operand} << 1;
   assign w_bcd_next = w_shifted[43:20];
   assign w_op_next  = w_shifted[19:0];

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (Start_Sig) w_state_next = StShift;
         StShift: if (r_cnt == LastStep) w_state_next = StDone;
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_operand <= '0;
         r_bcd     <= '0;
         r_cnt     <= '0;
         r_ovf     <= 1'b0;
         r_done    <= 1'b0;
         r_over    <= 1'b0;
         r_number  <= '0;
      end else begin
         r_done <= w_last;
         if (r_state == StIdle && Start_Sig) begin
            r_operand <= w_sat ? MAX_VALUE : Bin_Data;
            r_ovf     <= w_sat;
            r_bcd     <= '0;
            r_cnt     <= '0;
         end else if (r_state == StShift) begin
            r_bcd     <= w_bcd_next;
            r_operand <= w_op_next;
            r_cnt     <= r_cnt + 5'd1;
         end
         // Display outputs only move on completion, never mid-conversion.
         if (w_last) begin
            r_number <= w_bcd_next;
            r_over   <= r_ovf;
         end
      end
   end

   assign Busy_Sig   = (r_state != StIdle);
   assign Done_Sig   = r_done;
   assign Over_Sig   = r_over;
   assign Number_Sig = r_number;

endmodule

// File: tb/tb_smg_number_convert.sv
// Self-checking bench for smg_number_convert: cycle model plus directed scenarios.
module tb_smg_number_convert;

   localparam logic [19:0] MaxValue = 20'd999999;

   logic        CLK = 1'b0;
   logic        RSTn;
   logic        Start_Sig;
   logic [19:0] Bin_Data;
   logic        Busy_Sig;
   logic        Done_Sig;
   logic        Over_Sig;
   logic [23:0] Number_Sig;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   smg_number_convert #(.MAX_VALUE(MaxValue)) dut (
      .CLK        (CLK),
      .RSTn       (RSTn),
      .Start_Sig  (Start_Sig),
      .Bin_Data   (Bin_Data),
      .Busy_Sig   (Busy_Sig),
      .Done_Sig   (Done_Sig),
      .Over_Sig   (Over_Sig),
      .Number_Sig (Number_Sig)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] to_bcd(input logic [19:0] v);
      int unsigned n;
      logic [23:0] r;
      n = (v > MaxValue) ? int'(MaxValue) : int'(v);
      r = '0;
      for (int d = 0; d < 6; d++) begin
         r[4*d +: 4] = 4'(n % 10);
         n = n / 10;
      end
      return r;
   endfunction

   // Model: m_age counts edges since the accepted start edge, -1 when idle.
   int          m_age = -1;
   logic [23:0] m_pend = '0;
   logic        m_pend_ovf = 1'b0;
   logic [23:0] m_num = '0;
   logic        m_over = 1'b0;

   always @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         m_age  <= -1;
         m_num  <= '0;
         m_over <= 1'b0;
      end else if (m_age < 0) begin
         if (Start_Sig) begin
            m_age      <= 0;
            m_pend     <= to_bcd(Bin_Data);
            m_pend_ovf <= (Bin_Data > MaxValue);
         end
      end else begin
         if (m_age == 19) begin
            m_num  <= m_pend;
            m_over <= m_pend_ovf;
         end
         if (m_age == 20) m_age <= -1;
         else m_age <= m_age + 1;
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         check("cyc_busy", 32'(Busy_Sig), 32'(m_age >= 0));
         check("cyc_done", 32'(Done_Sig), 32'(m_age == 20));
         check("cyc_over", 32'(Over_Sig), 32'(m_over));
         check("cyc_num", 32'(Number_Sig), 32'(m_num));
      end
   end

   task automatic convert(input logic [19:0] v, input logic [23:0] exp_n, input logic exp_o,
                          input string name);
      bit got;
      int lat;
      int busy_n;
      Start_Sig = 1'b1;
      Bin_Data  = v;
      @(posedge CLK);
      #1;
      Start_Sig = 1'b0;
      Bin_Data  = 20'($urandom_range(0, 1048575));
      got = 1'b0;
      lat = -1;
      busy_n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (Busy_Sig) busy_n++;
         if (Done_Sig) begin
            got = 1'b1;
            lat = i;
            break;
         end
      end
      check({name, "_lat"}, 32'(lat), 32'd20);
      check({name, "_busy"}, 32'(busy_n), 32'd21);
      check({name, "_num"}, 32'(Number_Sig), 32'(exp_n));
      check({name, "_over"}, 32'(Over_Sig), 32'(exp_o));
      @(posedge CLK);
      #1;
   endtask

   initial begin
      int dones;
      int prev;
      Start_Sig = 1'b0;
      Bin_Data  = '0;
      RSTn      = 1'b1;
      #1;
      RSTn   = 1'b0;
      chk_en = 1'b1;
      #2;
      check("rst_num", 32'(Number_Sig), 32'h0);
      check("rst_flags", 32'({Busy_Sig, Done_Sig, Over_Sig}), 32'h0);
      check("pin_bcd_a", 32'(to_bcd(20'd123456)), 32'h123456);
      check("pin_bcd_sat", 32'(to_bcd(20'd1048575)), 32'h999999);
      repeat (2) @(negedge CLK);
      RSTn = 1'b1;
      @(posedge CLK);
      #1;

      convert(20'd0, 24'h000000, 1'b0, "zero");
      convert(20'd123456, 24'h123456, 1'b0, "v123456");
      convert(20'd999999, 24'h999999, 1'b0, "v999999");
      convert(20'd1048575, 24'h999999, 1'b1, "sat");
      convert(20'd42, 24'h000042, 1'b0, "v42");

      // Start re-pulsed mid-conversion with new data must be ignored.
      Start_Sig = 1'b1;
      Bin_Data  = 20'd65535;
      @(posedge CLK);
      #1;
      Start_Sig = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      Start_Sig = 1'b1;
      Bin_Data  = 20'd7;
      @(posedge CLK);
      #1;
      Start_Sig = 1'b0;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (Done_Sig) dones++;
      end
      check("ignore_dones", 32'(dones), 32'd1);
      check("ignore_num", 32'(Number_Sig), 32'h065535);
      @(posedge CLK);
      #1;

      // Reset mid-conversion aborts with no completion pulse.
      Start_Sig = 1'b1;
      Bin_Data  = 20'd500000;
      @(posedge CLK);
      #1;
      Start_Sig = 1'b0;
      dones = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge CLK);
         if (Done_Sig) dones++;
      end
      @(posedge CLK);
      #1;
      RSTn = 1'b0;
      #2;
      check("abort_num", 32'(Number_Sig), 32'h0);
      check("abort_flags", 32'({Busy_Sig, Done_Sig, Over_Sig}), 32'h0);
      check("abort_dones", 32'(dones), 32'd0);
      @(negedge CLK);
      RSTn = 1'b1;
      @(posedge CLK);
      #1;
      convert(20'd500000, 24'h500000, 1'b0, "after_rst");

      // Held Start retriggers every 22 clocks; display never shows partial values.
      Start_Sig = 1'b1;
      Bin_Data  = 20'd314159;
      @(posedge CLK);
      #1;
      prev  = -1;
      dones = 0;
      for (int i = 0; i < 70; i++) begin
         @(negedge CLK);
         if (Done_Sig) begin
            if (prev >= 0) check("held_period", 32'(i - prev), 32'd22);
            prev = i;
            dones++;
         end
         if (dones == 0) check("held_num_old", 32'(Number_Sig), 32'h500000);
         else check("held_num", 32'(Number_Sig), 32'h314159);
      end
      check("held_dones", 32'(dones), 32'd3);
      Start_Sig = 1'b0;
      repeat (30) @(posedge CLK);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/smg_number_convert.md
SMG_NUMBER_CONVERT -- requirements
Module: smg_number_convert

Interface
REQ-001 SHALL have parameter MAX_VALUE, default 20'd999999: largest value representable on the 6-digit display.
REQ-002 SHALL have port CLK  input  1  system clock; all registers update on its rising edge.
REQ-003 SHALL have port RSTn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port Start_Sig  input  1  conversion request, level sampled in IDLE.
REQ-005 SHALL have port Bin_Data  input  20  unsigned binary value to convert, sampled on the Start edge.
REQ-006 SHALL have port Busy_Sig  output  1  high while a conversion is in progress (state != IDLE).
REQ-007 SHALL have port Done_Sig  output  1  one-cycle completion pulse.
REQ-008 SHALL have port Over_Sig  output  1  last completed conversion was saturated.
REQ-009 SHALL have port Number_Sig  output  24  six packed BCD digits: [23:20] hundred-thousands down to [3:0] units; feeds the display scan controller directly.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-011 IDLE with Start_Sig=1 at an edge (edge 0) SHALL:
- latch the operand: Bin_Data if Bin_Data <= MAX_VALUE, else MAX_VALUE;
- record overflow as (Bin_Data > MAX_VALUE);
- clear the 24-bit BCD work register and the step counter;
- enter SHIFT.
REQ-012 SHIFT SHALL perform one double-dabble step per clock for 20 clocks (edges 1..20), step counter 0..19:
- add 3 to each BCD work nibble >= 5;
- shift the combined {BCD, operand} register left by 1.
REQ-013 At edge 20 (counter = 19) the block SHALL load Number_Sig with the final BCD value, load Over_Sig with the recorded overflow flag, and enter DONE.
REQ-014 In DONE Done_Sig SHALL be 1 for exactly one cycle; at the next edge the FSM SHALL return to IDLE and Done_Sig SHALL return to 0.
REQ-015 Done_Sig SHALL be a registered output, high in the cycle between edges 20 and 21 after the Start edge, giving a latency of 20 clocks from the Start sample to Done.
REQ-016 Busy_Sig SHALL be high in SHIFT and DONE (edge 0 to edge 21) and low in IDLE.
REQ-017 Number_Sig and Over_Sig SHALL hold their previous values throughout SHIFT and change only at the DONE entry edge, so the display never shows intermediate values.
REQ-018 Start_Sig SHALL be ignored in SHIFT and DONE, with no queuing.
REQ-019 Continuously high Start_Sig SHALL retrigger conversions with a period of 22 clocks (one IDLE cycle between conversions).
REQ-020 Every Number_Sig nibble SHALL always be in the range 0..9.
REQ-021 Bin_Data changes after the Start edge SHALL not affect the conversion in progress.

Reset
REQ-022 RSTn=0 SHALL immediately force the following regardless of CLK:
- state IDLE;
- Number_Sig=24'h000000;
- Over_Sig=0, Done_Sig=0, Busy_Sig=0;
- step counter and work registers to 0.
REQ-023 Reset asserted mid-conversion SHALL abort the conversion with no Done_Sig pulse.
REQ-024 After RSTn deasserts, the first Start_Sig sampled in IDLE SHALL begin a fresh conversion.

Verification
REQ-025 Bench SHALL cover: Bin_Data=0 -> Done_Sig 20 clocks after Start, Number_Sig=24'h000000, Over_Sig=0, Busy_Sig high for 21 clocks.
REQ-026 Bench SHALL cover: Bin_Data=123456 then Bin_Data=999999 -> Number_Sig=24'h123456 then 24'h999999, Over_Sig=0 for both.
REQ-027 Bench SHALL cover: Bin_Data=1048575 -> Number_Sig=24'h999999, Over_Sig=1; next conversion of 42 -> 24'h000042, Over_Sig=0.
REQ-028 Bench SHALL cover: Start_Sig pulsed again at cycle 5 of a conversion of 65535, with Bin_Data changed to 7 -> exactly one Done_Sig, Number_Sig=24'h065535.
REQ-029 Bench SHALL cover: RSTn pulsed low at cycle 10 of a conversion of 500000 -> all outputs 0 with no Done_Sig; a new Start with 500000 -> 24'h500000.
REQ-030 Bench SHALL cover: Start_Sig held high with Bin_Data=314159 -> Done_Sig every 22 clocks, Number_Sig stable at 24'h314159 with no intermediate values.
